// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store front-end for a word-only data memory.
//               Sub-word stores are done as read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [2:0]   req_funct3,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_fault,
  output logic [N-1:0] mem_addr,
  output logic         mem_we,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);

  localparam logic [N-1:0] c_byte_mask = N'(8'hFF);
  localparam logic [N-1:0] c_half_mask = N'(16'hFFFF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t       r_state;
  logic [N-1:0] r_addr;
  logic [2:0]   r_funct3;
  logic [N-1:0] r_wdata;
  logic [N-1:0] r_merge;
  logic         r_mem_we;
  logic         r_resp_valid;
  logic         r_resp_fault;
  logic [N-1:0] r_resp_rdata;

  logic         w_accept;
  logic         w_fault;
  logic [4:0]   w_shamt;
  logic [N-1:0] w_shifted;
  logic [N-1:0] w_mask;
  logic [N-1:0] w_merge;
  logic [N-1:0] w_load_data;

  assign w_accept = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_fault = 1'b0;
    case (req_funct3)
      3'b000:  w_fault = 1'b0;
      3'b001:  w_fault = req_addr[0];
      3'b010:  w_fault = |req_addr[1:0];
      3'b100:  w_fault = req_write;
      3'b101:  w_fault = req_write | req_addr[0];
      default: w_fault = 1'b1;
    endcase
  end

  // Bit offset of the addressed lane; words always sit at offset 0.
  always_comb begin
    w_shamt = 5'd0;
    case (r_funct3[1:0])
      2'b00:   w_shamt = {r_addr[1:0], 3'b000};
      2'b01:   w_shamt = {r_addr[1], 4'b0000};
      default: w_shamt = 5'd0;
    endcase
  end

  assign w_shifted = mem_rdata >> w_shamt;
  assign w_mask    = (r_funct3[0] ? c_half_mask : c_byte_mask) << w_shamt;
  assign w_merge   = (mem_rdata & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

  always_comb begin
    w_load_data = w_shifted;
    case (r_funct3)
      3'b000:  w_load_data = {{(N-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {{(N-8){1'b0}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{(N-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {{(N-16){1'b0}}, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_funct3     <= '0;
      r_wdata      <= '0;
      r_merge      <= '0;
      r_mem_we     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= req_addr;
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
            if (w_fault) begin
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_rdata <= '0;
            end else if (!req_write) begin
              r_state <= S_LOAD;
            end else if (req_funct3 == 3'b010) begin
              r_merge  <= req_wdata;
              r_mem_we <= 1'b1;
              r_state  <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_LOAD: begin
          r_resp_rdata <= w_load_data;
          r_resp_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        S_READ: begin
          r_merge  <= w_merge;
          r_mem_we <= 1'b1;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_mem_we     <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_fault = r_resp_fault;
  assign resp_rdata = r_resp_rdata;
  assign mem_addr   = {r_addr[N-1:2], 2'b00};
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_merge;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               small word memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [64];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end
  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    bd_idx = idx; bd_data = data; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Called just after a negedge with the DUT idle; returns just after the
  // negedge on which resp_valid was seen (or after the cycle budget).
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic fault, output int lat, output int we_cnt,
                        output int we_at, output logic [31:0] we_data);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1; we_cnt = 0; we_at = -1; we_data = '0; rdata = '0; fault = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_at = c; we_data = mem_wdata; end
      if (resp_valid) begin lat = c; rdata = resp_rdata; fault = resp_fault; break; end
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
  } flt_vec_t;

  initial begin
    logic [31:0] rd, wd;
    logic        flt;
    int          lat, lat2, wc, wa;
    ld_vec_t     lv [6];
    flt_vec_t    fv [4];

    lv[0] = '{3'b000, 32'h21, 32'h0000007F};
    lv[1] = '{3'b000, 32'h22, 32'hFFFFFFFF};
    lv[2] = '{3'b100, 32'h23, 32'h00000080};
    lv[3] = '{3'b001, 32'h22, 32'hFFFF80FF};
    lv[4] = '{3'b101, 32'h20, 32'h00007F01};
    lv[5] = '{3'b010, 32'h20, 32'h80FF7F01};
    fv[0] = '{1'b0, 3'b010, 32'h06};
    fv[1] = '{1'b1, 3'b001, 32'h0B};
    fv[2] = '{1'b0, 3'b011, 32'h00};
    fv[3] = '{1'b1, 3'b100, 32'h10};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    poke(6'd4, 32'h11223344);
    poke(6'd8, 32'h80FF7F01);
    poke(6'd16, 32'hCAFEF00D);
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // SB into the middle of a word
    do_req(1'b1, 3'b000, 32'h12, 32'h000000AB, rd, flt, lat, wc, wa, wd);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_we_cnt", 32'(wc), 32'd1);
    check("sb_we_at", 32'(wa), 32'd2);
    check("sb_wdata", wd, 32'h11AB3344);
    check("sb_fault", {31'b0, flt}, 32'd0);
    check("sb_rdata", rd, 32'd0);
    check("sb_mem", mem[4], 32'h11AB3344);

    foreach (lv[i]) begin
      do_req(1'b0, lv[i].f3, lv[i].addr, 32'h0, rd, flt, lat, wc, wa, wd);
      check($sformatf("ld%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("ld%0d_data", i), rd, lv[i].exp);
      check($sformatf("ld%0d_fault", i), {31'b0, flt}, 32'd0);
    end

    foreach (fv[i]) begin
      do_req(fv[i].w, fv[i].f3, fv[i].addr, 32'hFFFFFFFF, rd, flt, lat, wc, wa, wd);
      check($sformatf("flt%0d_lat", i), 32'(lat), 32'd1);
      check($sformatf("flt%0d_fault", i), {31'b0, flt}, 32'd1);
      check($sformatf("flt%0d_rdata", i), rd, 32'd0);
      check($sformatf("flt%0d_we", i), 32'(wc), 32'd0);
    end
    check("flt_mem_unchanged", mem[4], 32'h11AB3344);

    // SW then back-to-back LW in the response cycle
    do_req(1'b1, 3'b010, 32'h30, 32'hDEADBEEF, rd, flt, lat, wc, wa, wd);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_we_at", 32'(wa), 32'd1);
    check("sw_ready_in_resp", {31'b0, req_ready}, 32'd1);
    do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, flt, lat2, wc, wa, wd);
    check("raw_total_lat", 32'(lat + lat2), 32'd4);
    check("raw_data", rd, 32'hDEADBEEF);

    // Reset while in READ
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h40; req_wdata = 32'h00001234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_ready_read", {31'b0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready", {31'b0, req_ready}, 32'd1);
    wc = 0; wa = 0;
    for (int c = 0; c < 4; c++) begin
      if (mem_we) wc++;
      if (resp_valid) wa++;
      @(negedge clk);
    end
    check("rstmid_no_we", 32'(wc), 32'd0);
    check("rstmid_no_resp", 32'(wa), 32'd0);
    check("rstmid_mem", mem[16], 32'hCAFEF00D);

    // Held req_valid with changing address while busy (load)
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b001; req_addr = 32'h22;
    @(posedge clk); #1;
    req_addr = 32'h20;
    @(negedge clk);
    check("hold_ld_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("hold_ld_valid", {31'b0, resp_valid}, 32'd1);
    check("hold_ld_data", resp_rdata, 32'hFFFF80FF);
    @(negedge clk);

    // Held req_valid with changing address while busy (sub-word store)
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h13; req_wdata = 32'h0000005A;
    @(posedge clk); #1;
    req_addr = 32'h11; req_wdata = 32'h0;
    @(negedge clk);
    check("hold_sb_ready_read", {31'b0, req_ready}, 32'd0);
    check("hold_sb_addr", mem_addr, 32'h10);
    @(negedge clk);
    check("hold_sb_ready_write", {31'b0, req_ready}, 32'd0);
    check("hold_sb_we", {31'b0, mem_we}, 32'd1);
    check("hold_sb_wdata", mem_wdata, 32'h5AAB3344);
    @(negedge clk);
    req_valid = 1'b0;
    check("hold_sb_resp", {31'b0, resp_valid}, 32'd1);
    @(negedge clk);
    check("hold_sb_mem", mem[4], 32'h5AAB3344);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
